// File: rtl/rc_nrzi_unstuff.sv
// USB receive front end: SYNC lock, NRZI decode, bit unstuffing and EOP detection.
// Optional build macro RC_NRZI_STRICT_EOP_EN: exact two-SE0 EOP and SE1 abort in every non-idle state.
module rc_nrzi_unstuff #(
    parameter int SYNC_LEN  = 8,
    parameter int STUFF_RUN = 6,
    parameter int MAX_BITS  = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic dp,
    input  logic dm,
    output logic s_in,
    output logic s_valid,
    output logic start_rc_crc,
    output logic end_rc_crc,
    output logic rx_active,
    output logic rc_abort,
    output logic stuff_err
);

    localparam int SW = $clog2(SYNC_LEN);
    localparam int OW = $clog2(STUFF_RUN + 1);
    localparam int BW = $clog2(MAX_BITS + 1);

    localparam logic [1:0] LINE_SE0 = 2'b00;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_SE1 = 2'b11;

    localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_LEN - 1);
    localparam logic [OW-1:0] ONES_MAX  = OW'(STUFF_RUN);
    localparam logic [BW-1:0] BITS_MAX  = BW'(MAX_BITS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP,
        ST_WAIT_J
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    line_q, line_d;
    logic [1:0]    prev_q, prev_d;
    logic [SW-1:0] sync_cnt_q, sync_cnt_d;
    logic [OW-1:0] ones_q, ones_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic          first_q, first_d;
    logic          eop_ok_q, eop_ok_d;
    logic          s_in_q, s_in_d;
    logic          s_valid_q, s_valid_d;
    logic          start_q, start_d;
    logic          end_q, end_d;
    logic          rx_active_q, rx_active_d;
    logic          abort_q, abort_d;
    logic          stuff_err_q, stuff_err_d;

    logic [1:0]    data_line;
    logic          bit_val;
    logic          sync_toggle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            line_q      <= '0;
            prev_q      <= '0;
            sync_cnt_q  <= '0;
            ones_q      <= '0;
            bit_cnt_q   <= '0;
            first_q     <= 1'b0;
            eop_ok_q    <= 1'b0;
            s_in_q      <= 1'b0;
            s_valid_q   <= 1'b0;
            start_q     <= 1'b0;
            end_q       <= 1'b0;
            rx_active_q <= 1'b0;
            abort_q     <= 1'b0;
            stuff_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            prev_q      <= prev_d;
            sync_cnt_q  <= sync_cnt_d;
            ones_q      <= ones_d;
            bit_cnt_q   <= bit_cnt_d;
            first_q     <= first_d;
            eop_ok_q    <= eop_ok_d;
            s_in_q      <= s_in_d;
            s_valid_q   <= s_valid_d;
            start_q     <= start_d;
            end_q       <= end_d;
            rx_active_q <= rx_active_d;
            abort_q     <= abort_d;
            stuff_err_q <= stuff_err_d;
        end
    end

    always_comb begin
        line_d      = {dp, dm};
        state_d     = state_q;
        prev_d      = prev_q;
        sync_cnt_d  = sync_cnt_q;
        ones_d      = ones_q;
        bit_cnt_d   = bit_cnt_q;
        first_d     = first_q;
        eop_ok_d    = eop_ok_q;
        s_in_d      = s_in_q;
        s_valid_d   = 1'b0;
        start_d     = 1'b0;
        end_d       = 1'b0;
        rx_active_d = rx_active_q;
        abort_d     = 1'b0;
        stuff_err_d = 1'b0;
        bit_val     = 1'b0;
        sync_toggle = ((line_q == LINE_J) && (prev_q == LINE_K)) ||
                      ((line_q == LINE_K) && (prev_q == LINE_J));
`ifdef RC_NRZI_STRICT_EOP_EN
        data_line   = line_q;
`else
        // Lenient build: a stray SE1 inside the payload decodes as J.
        data_line   = (line_q == LINE_SE1) ? LINE_J : line_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (line_q == LINE_K) begin
                    sync_cnt_d = SW'(1);
                    prev_d     = LINE_K;
                    state_d    = ST_SYNC;
                end
            end

            ST_SYNC: begin
                if (line_q == LINE_SE1) begin
                    abort_d  = 1'b1;
                    eop_ok_d = 1'b0;
                    state_d  = ST_WAIT_J;
                end else if (sync_toggle && (sync_cnt_q < SYNC_LAST)) begin
                    sync_cnt_d = sync_cnt_q + 1'b1;
                    prev_d     = line_q;
                end else if ((line_q == LINE_K) && (prev_q == LINE_K) &&
                             (sync_cnt_q == SYNC_LAST)) begin
                    state_d     = ST_DATA;
                    prev_d      = LINE_K;
                    ones_d      = '0;
                    bit_cnt_d   = '0;
                    first_d     = 1'b1;
                    eop_ok_d    = 1'b0;
                    rx_active_d = 1'b1;
                end else begin
                    // Not a recognised SYNC yet, so drop back without an abort.
                    state_d = ST_IDLE;
                end
            end

            ST_DATA: begin
                if (line_q == LINE_SE0) begin
                    state_d = ST_EOP;
`ifdef RC_NRZI_STRICT_EOP_EN
                end else if (line_q == LINE_SE1) begin
                    abort_d     = 1'b1;
                    rx_active_d = 1'b0;
                    eop_ok_d    = 1'b0;
                    state_d     = ST_WAIT_J;
`endif
                end else begin
                    bit_val = (data_line == prev_q);
                    prev_d  = data_line;
                    if (ones_q == ONES_MAX) begin
                        if (bit_val) begin
                            stuff_err_d = 1'b1;
                            abort_d     = 1'b1;
                            rx_active_d = 1'b0;
                            eop_ok_d    = 1'b0;
                            state_d     = ST_WAIT_J;
                        end else begin
                            ones_d = '0;
                        end
                    end else begin
                        s_valid_d = 1'b1;
                        s_in_d    = bit_val;
                        start_d   = first_q;
                        first_d   = 1'b0;
                        ones_d    = bit_val ? ones_q + 1'b1 : '0;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        // Babble: the bit that reaches the limit is still delivered.
                        if (bit_cnt_d == BITS_MAX) begin
                            abort_d     = 1'b1;
                            rx_active_d = 1'b0;
                            eop_ok_d    = 1'b0;
                            state_d     = ST_WAIT_J;
                        end
                    end
                end
            end

            ST_EOP: begin
                state_d = ST_WAIT_J;
                if (line_q == LINE_SE0) begin
                    eop_ok_d = 1'b1;
                end else begin
                    abort_d     = 1'b1;
                    rx_active_d = 1'b0;
                    eop_ok_d    = 1'b0;
                end
            end

            ST_WAIT_J: begin
                unique case (line_q)
                    LINE_J: begin
                        end_d       = eop_ok_q;
                        rx_active_d = 1'b0;
                        eop_ok_d    = 1'b0;
                        state_d     = ST_IDLE;
                    end
                    LINE_SE1: begin
                        abort_d     = 1'b1;
                        rx_active_d = 1'b0;
                        eop_ok_d    = 1'b0;
                    end
`ifdef RC_NRZI_STRICT_EOP_EN
                    LINE_SE0: begin
                        if (eop_ok_q) begin
                            abort_d     = 1'b1;
                            rx_active_d = 1'b0;
                            eop_ok_d    = 1'b0;
                        end
                    end
`endif
                    default: ;
                endcase
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign s_in         = s_in_q;
    assign s_valid      = s_valid_q;
    assign start_rc_crc = start_q;
    assign end_rc_crc   = end_q;
    assign rx_active    = rx_active_q;
    assign rc_abort     = abort_q;
    assign stuff_err    = stuff_err_q;

endmodule

// File: tb/tb_rc_nrzi_unstuff.sv
// Directed bench for rc_nrzi_unstuff; each output vector is {s_valid,s_in,start,end,rx_active,abort,stuff_err}.
module tb_rc_nrzi_unstuff;

    localparam logic [1:0] J  = 2'b10;
    localparam logic [1:0] K  = 2'b01;
    localparam logic [1:0] S0 = 2'b00;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic dp    = 1'b0;
    logic dm    = 1'b0;
    logic s_in, s_valid, start_rc_crc, end_rc_crc, rx_active, rc_abort, stuff_err;

    int errors = 0;
    int checks = 0;
    logic [6:0] pend_exp = '0;
    string pend_tag = "reset_release";

    rc_nrzi_unstuff dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dp           (dp),
        .dm           (dm),
        .s_in         (s_in),
        .s_valid      (s_valid),
        .start_rc_crc (start_rc_crc),
        .end_rc_crc   (end_rc_crc),
        .rx_active    (rx_active),
        .rc_abort     (rc_abort),
        .stuff_err    (stuff_err)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {s_valid, s_in, start_rc_crc, end_rc_crc, rx_active, rc_abort, stuff_err};
    endfunction

    task automatic check(input string tag, input logic [6:0] exp);
        checks++;
        assert (outs() === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, outs(), exp);
        end
    endtask

    // Drive one bus sample; the outputs seen after this edge answer the previous sample.
    task automatic step(input logic [1:0] sym, input logic [6:0] exp, input string tag);
        {dp, dm} = sym;
        @(posedge clk);
        #1;
        check(pend_tag, pend_exp);
        pend_exp = exp;
        pend_tag = tag;
    endtask

    task automatic sync_seq(input logic si, input string tag);
        for (int i = 0; i < 7; i++)
            step((i % 2 == 0) ? K : J, {1'b0, si, 5'b00000}, tag);
        step(K, {1'b0, si, 5'b00100}, tag);
    endtask

    initial begin
        // Reset held with random bus values
        for (int i = 0; i < 4; i++) begin
            {dp, dm} = 2'($urandom_range(0, 3));
            @(posedge clk);
            #1;
            check("reset_hold", 7'b0000000);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(J, 7'b0000000, "idle_j");

        // Good packet: payload 11000011
        sync_seq(1'b0, "good_sync");
        step(K,  7'b1110100, "good_b0");
        step(K,  7'b1100100, "good_b1");
        step(J,  7'b1000100, "good_b2");
        step(K,  7'b1000100, "good_b3");
        step(J,  7'b1000100, "good_b4");
        step(K,  7'b1000100, "good_b5");
        step(K,  7'b1100100, "good_b6");
        step(K,  7'b1100100, "good_b7");
        step(S0, 7'b0100100, "good_se0a");
        step(S0, 7'b0100100, "good_se0b");
        step(J,  7'b0101000, "good_end");
        step(J,  7'b0100000, "good_idle");

        // Stuffing: six 1s, dropped stuff bit, then a 0
        sync_seq(1'b1, "stf_sync");
        step(K,  7'b1110100, "stf_one0");
        for (int i = 0; i < 5; i++) step(K, 7'b1100100, "stf_ones");
        step(J,  7'b0100100, "stf_drop");
        step(K,  7'b1000100, "stf_zero");
        step(S0, 7'b0000100, "stf_se0a");
        step(S0, 7'b0000100, "stf_se0b");
        step(J,  7'b0001000, "stf_end");
        step(J,  7'b0000000, "stf_idle");

        // Stuff violation: seventh repeated symbol
        sync_seq(1'b0, "vio_sync");
        step(K,  7'b1110100, "vio_one0");
        for (int i = 0; i < 5; i++) step(K, 7'b1100100, "vio_ones");
        step(K,  7'b0100011, "vio_err");
        step(S0, 7'b0100000, "vio_se0a");
        step(S0, 7'b0100000, "vio_se0b");
        step(J,  7'b0100000, "vio_noend");
        step(J,  7'b0100000, "vio_idle");

        // Bad SYNC KJKJJ
        step(K,  7'b0100000, "bad_sync");
        step(J,  7'b0100000, "bad_sync");
        step(K,  7'b0100000, "bad_sync");
        step(J,  7'b0100000, "bad_sync");
        step(J,  7'b0100000, "bad_sync_drop");
        step(J,  7'b0100000, "bad_sync_idle");
        step(J,  7'b0100000, "bad_sync_idle");

        // Single-SE0 EOP aborts
        sync_seq(1'b1, "one_se0_sync");
        step(K,  7'b1110100, "one_se0_b0");
        step(J,  7'b1000100, "one_se0_b1");
        step(S0, 7'b0000100, "one_se0_se0");
        step(J,  7'b0000010, "one_se0_abort");
        step(J,  7'b0000000, "one_se0_noend");
        step(J,  7'b0000000, "one_se0_idle");

        // Empty packet: EOP straight after SYNC
        sync_seq(1'b0, "empty_sync");
        step(S0, 7'b0000100, "empty_se0a");
        step(S0, 7'b0000100, "empty_se0b");
        step(J,  7'b0001000, "empty_end");
        step(J,  7'b0000000, "empty_idle");

        // EOP while a stuff bit is pending
        sync_seq(1'b0, "pend_sync");
        step(K,  7'b1110100, "pend_one0");
        for (int i = 0; i < 5; i++) step(K, 7'b1100100, "pend_ones");
        step(S0, 7'b0100100, "pend_se0a");
        step(S0, 7'b0100100, "pend_se0b");
        step(J,  7'b0101000, "pend_end");
        step(J,  7'b0100000, "pend_idle");

        // Babble: the 1024th emitted bit aborts
        sync_seq(1'b1, "babble_sync");
        for (int i = 0; i < 1024; i++)
            step((i % 2 == 0) ? J : K,
                 (i == 0) ? 7'b1010100 : ((i == 1023) ? 7'b1000010 : 7'b1000100),
                 "babble");
        step(S0, 7'b0000000, "babble_se0a");
        step(S0, 7'b0000000, "babble_se0b");
        step(J,  7'b0000000, "babble_noend");
        step(J,  7'b0000000, "babble_idle");

        // Reset in the middle of a packet
        sync_seq(1'b0, "mid_sync");
        step(K,  7'b1110100, "mid_b0");
        for (int i = 0; i < 4; i++) step(K, 7'b1100100, "mid_bits");
        rst_n = 1'b0;
        #1;
        check("mid_reset", 7'b0000000);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pend_exp = '0;
        pend_tag = "mid_release";

        // Good packet after reset: payload 0010
        sync_seq(1'b0, "post_sync");
        step(J,  7'b1010100, "post_b0");
        step(K,  7'b1000100, "post_b1");
        step(K,  7'b1100100, "post_b2");
        step(J,  7'b1000100, "post_b3");
        step(S0, 7'b0000100, "post_se0a");
        step(S0, 7'b0000100, "post_se0b");
        step(J,  7'b0001000, "post_end");
        step(J,  7'b0000000, "post_idle");
        step(J,  7'b0000000, "flush");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
